// File: rtl/md_sched_if.sv
// HI/LO multiply/divide sequencer interface: E-stage request, D-stage
// use flag, and the busy/stall/HI/LO results returned by md_sched.
interface md_sched_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  start, op, a, b, d_md_use,
        output busy, stall, hi, lo
    );

    modport master (
        output start, op, a, b, d_md_use,
        input  busy, stall, hi, lo
    );
endinterface

// File: rtl/md_sched.sv
// HI/LO multiply/divide sequencer. The result is computed when the op
// enters E and parked in pending registers; the unit then stays busy for a
// fixed latency and commits to HI/LO on the last busy edge. While busy (or
// while an md op is entering E) any D-stage HI/LO user is stalled.
module md_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    md_sched_if.slave   md
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state;
    logic [3:0]  count;
    logic        busy_q;
    logic        keep_q;     // divide by zero: leave HI/LO untouched at commit
    logic [31:0] ph, pl;
    logic [31:0] hi_q, lo_q;

    logic [63:0] prod;
    logic [31:0] quo, rem;
    logic        div_zero;

    // Arithmetic for the op currently presented in E.
    always_comb begin
        logic signed [63:0] sa64, sb64;
        logic signed [31:0] sa, sb;
        logic [31:0]        bsafe;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        prod     = '0;
        quo      = '0;
        rem      = '0;
        div_zero = (md.b == 32'd0);
        bsafe    = div_zero ? 32'd1 : md.b;
        sa64     = {{32{md.a[31]}}, md.a};
        sb64     = {{32{md.b[31]}}, md.b};
        sa       = md.a;
        sb       = bsafe;
        case (md.op)
            OP_MULT:  prod = 64'(sa64 * sb64);
            OP_MULTU: prod = {32'd0, md.a} * {32'd0, md.b};
            OP_DIV: begin
                // -2^31 / -1 overflows; pin the architected result explicitly.
                if (md.a == 32'h8000_0000 && md.b == 32'hFFFF_FFFF) begin
                    quo = 32'h8000_0000;
                    rem = 32'd0;
                end else begin
                    quo = 32'(sa / sb);
                    rem = 32'(sa % sb);
                end
            end
            OP_DIVU: begin
                quo = md.a / bsafe;
                rem = md.a % bsafe;
            end
            default: ;
        endcase
    end

    // Sequencer FSM: accept ops in IDLE, count down in RUN, commit on the last busy edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= '0;
            busy_q <= 1'b0;
            keep_q <= 1'b0;
            ph     <= '0;
            pl     <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (md.start) begin
                        case (md.op)
                            OP_MULT, OP_MULTU: begin
                                {ph, pl} <= prod;
                                keep_q   <= 1'b0;
                                count    <= 4'(MUL_CYCLES);
                                busy_q   <= 1'b1;
                                state    <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                ph     <= rem;
                                pl     <= quo;
                                keep_q <= div_zero;
                                count  <= 4'(DIV_CYCLES);
                                busy_q <= 1'b1;
                                state  <= RUN;
                            end
                            OP_MTHI: hi_q <= md.a;
                            OP_MTLO: lo_q <= md.a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // A start here is a pipeline protocol error and is ignored.
                    if (count == 4'd1) begin
                        if (!keep_q) begin
                            hi_q <= ph;
                            lo_q <= pl;
                        end
                        count  <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md.busy  = busy_q;
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;
    // Stall a D-stage HI/LO user while busy or while a mult/div enters E (op 0..3).
    assign md.stall = md.d_md_use & (busy_q | (md.start & ~md.op[2]));

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: busy latency, HI/LO results, stall window,
// MTHI/MTLO, divide by zero, back-to-back ops and asynchronous reset.
module tb_md_sched;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    md_sched_if bus();

    md_sched dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (bus)
    );

    always #5 clk = ~clk;

    // A mult/div entering E while the unit is busy is a pipeline protocol error.
    always @(posedge clk) begin
        if (reset_n && bus.start === 1'b1 && bus.busy === 1'b1 && bus.op[2] === 1'b0) begin
            failures++;
            $display("FAIL protocol: start of op %0d while busy", bus.op);
        end
    end

    // Present one op in E for a single cycle; caller is at a negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd7;
    endtask

    // Count busy cycles (sampled at negedges) and note any HI/LO change while busy.
    task automatic wait_idle(output int cycles, output logic changed);
        logic [31:0] h0, l0;
        h0 = bus.hi;
        l0 = bus.lo;
        cycles  = 0;
        changed = 1'b0;
        while (bus.busy === 1'b1 && cycles < 64) begin
            cycles++;
            if (bus.hi !== h0 || bus.lo !== l0) changed = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int c; logic ch;
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_idle(c, ch);
        checks++; if (c != 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", c); end
        checks++; if (ch !== 1'b0) begin failures++; $display("FAIL mult_hilo_changed_while_busy"); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", bus.lo); end
        @(negedge clk);
    endtask

    task automatic test_multu();
        int c; logic ch;
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_idle(c, ch);
        checks++; if (c != 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", c); end
        checks++; if (bus.hi !== 32'h0000_0001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", bus.lo); end
        @(negedge clk);
    endtask

    task automatic test_div_stall();
        int   n;
        logic stall_bad;
        bus.d_md_use = 1'b1;
        bus.start    = 1'b1;
        bus.op       = 3'd2;
        bus.a        = 32'hFFFF_FFF9;
        bus.b        = 32'd2;
        #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL div_stall_start_cycle got=%b exp=1", bus.stall); end
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd7;
        n = 0;
        stall_bad = 1'b0;
        while (bus.busy === 1'b1 && n < 64) begin
            n++;
            if (bus.stall !== 1'b1) stall_bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (n != 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
        checks++; if (stall_bad !== 1'b0) begin failures++; $display("FAIL div_stall_while_busy dropped"); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL div_stall_after got=%b exp=0", bus.stall); end
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", bus.hi); end
        bus.d_md_use = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div_signs();
        int c; logic ch;
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(c, ch);
        checks++; if (bus.lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", bus.lo); end
        checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=00000000", bus.hi); end
        @(negedge clk);
        // 7 / -2 = -3 remainder 1
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_idle(c, ch);
        checks++; if (bus.lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_negb_lo got=%h exp=fffffffd", bus.lo); end
        checks++; if (bus.hi !== 32'd1) begin failures++; $display("FAIL div_negb_hi got=%h exp=00000001", bus.hi); end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int c; logic ch;
        bus.d_md_use = 1'b1;
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h11;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%b exp=0", bus.stall); end
        @(negedge clk);
        bus.op = 3'd5; bus.a = 32'h22;
        checks++; if (bus.hi !== 32'h11) begin failures++; $display("FAIL preset_hi got=%h exp=00000011", bus.hi); end
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd7;
        bus.d_md_use = 1'b0;
        checks++; if (bus.lo !== 32'h22) begin failures++; $display("FAIL preset_lo got=%h exp=00000022", bus.lo); end
        issue(3'd3, 32'd100, 32'd0);
        wait_idle(c, ch);
        checks++; if (c != 10) begin failures++; $display("FAIL divz_busy_cycles got=%0d exp=10", c); end
        checks++; if (bus.hi !== 32'h11) begin failures++; $display("FAIL divz_hi got=%h exp=00000011", bus.hi); end
        checks++; if (bus.lo !== 32'h22) begin failures++; $display("FAIL divz_lo got=%h exp=00000022", bus.lo); end
        @(negedge clk);
    endtask

    task automatic test_mthi();
        bus.d_md_use = 1'b1;
        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h1234_5678;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL mthi2_stall got=%b exp=0", bus.stall); end
        checks++; if (bus.hi !== 32'h11) begin failures++; $display("FAIL mthi2_hi_early got=%h exp=00000011", bus.hi); end
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd7;
        checks++; if (bus.hi !== 32'h1234_5678) begin failures++; $display("FAIL mthi2_hi got=%h exp=12345678", bus.hi); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mthi2_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.lo !== 32'h22) begin failures++; $display("FAIL mthi2_lo got=%h exp=00000022", bus.lo); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mthi2_busy_later got=%b exp=0", bus.busy); end
        bus.d_md_use = 1'b0;
    endtask

    task automatic test_back_to_back();
        int c; logic ch;
        issue(3'd1, 32'h0001_0000, 32'h0001_0000);
        wait_idle(c, ch);
        checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'd0) begin failures++; $display("FAIL b2b_first got=%h_%h exp=00000001_00000000", bus.hi, bus.lo); end
        // second op enters in the same cycle busy drops
        issue(3'd3, 32'd100, 32'd7);
        wait_idle(c, ch);
        checks++; if (c != 10) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=10", c); end
        checks++; if (bus.lo !== 32'd14) begin failures++; $display("FAIL b2b_lo got=%h exp=0000000e", bus.lo); end
        checks++; if (bus.hi !== 32'd2) begin failures++; $display("FAIL b2b_hi got=%h exp=00000002", bus.hi); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c; logic ch;
        issue(3'd3, 32'd50, 32'd7);
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", bus.busy); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.hi !== 32'd0) begin failures++; $display("FAIL rstmid_hi got=%h exp=0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin failures++; $display("FAIL rstmid_lo got=%h exp=0", bus.lo); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle_busy got=%b exp=0", bus.busy); end
        issue(3'd0, 32'd7, 32'd6);
        wait_idle(c, ch);
        checks++; if (c != 5) begin failures++; $display("FAIL rstmid_mult_cycles got=%0d exp=5", c); end
        checks++; if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin failures++; $display("FAIL rstmid_mult got=%h_%h exp=00000000_0000002a", bus.hi, bus.lo); end
        @(negedge clk);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.op       = 3'd7;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.d_md_use = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div_stall();
        test_div_signs();
        test_div_zero();
        test_mthi();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Sequencing controller for the HI/LO multiply/divide resource in the E stage of the 5-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and holds the unit busy for a fixed multi-cycle latency.
- Commits results to HI/LO at completion.
- Raises a stall request whenever the D-stage instruction needs the HI/LO resource while it is occupied.
- Complements the Tuse/Tnew hazard logic: that logic covers GPR hazards, this block covers HI/LO occupancy.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  E-stage instruction is a valid md/mt op this cycle.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op.
- a  in  32  rs operand, already forwarded.
- b  in  32  rt operand, already forwarded.
- d_md_use  in  1  D-stage instruction is mult/div/mf/mt.
- busy  out  1  a multiply or divide is in flight.
- stall  out  1  combinational; D-stage stall request.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, counter=0.
  - busy=0, hi=0, lo=0, pending result registers=0.
  - Applies immediately, including mid-operation; the in-flight result is discarded.
- States: IDLE, RUN.
- IDLE, start=1 sampled at edge t0:
  - op 0/1: latch 64-bit product into pending {ph,pl}; counter<=MUL_CYCLES; go to RUN.
  - op 2/3: latch quotient into pl and remainder into ph; counter<=DIV_CYCLES; go to RUN.
  - op 4: hi<=a at t0; stay in IDLE; busy stays 0.
  - op 5: lo<=a at t0; stay in IDLE; busy stays 0.
  - op 6/7: no effect.
- RUN:
  - busy=1 and counter decrements each edge.
  - At the edge where counter==1: hi<=ph, lo<=pl, counter<=0, go to IDLE.
  - Net timing: busy is high for exactly N cycles (t0+1 .. t0+N); new hi/lo are visible from cycle t0+N+1.
- start while in RUN: ignored, no state change. The stall output guarantees this cannot occur in a correct pipeline; the bench flags it as a protocol error.
- Arithmetic:
  - MULT: signed 32x32 -> 64.
  - MULTU: unsigned 32x32 -> 64.
  - hi = product[63:32], lo = product[31:0].
  - DIV: signed; quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned.
  - b==0 on DIV/DIVU: full DIV_CYCLES are still taken; hi/lo are left unchanged at completion.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- Stall: stall = d_md_use & (busy | (start & op<=3)).
  - Covers the cycle in which an md op enters E and every busy cycle.
  - Drops in cycle t0+N+1, so the stalled mf reads the committed value.
- Back-to-back: a second md op may start at cycle t0+N+1, the same cycle busy drops.
- MTHI/MTLO never set busy. They cannot overlap RUN, because stall holds them in D.
- hi/lo only change at MTHI/MTLO edges or at completion edges.

Test Plan:
- Reset then MULT a=0xFFFFFFFE(-2) b=3, with default parameters:
  - busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - hi/lo stay 0 while busy.
- MULTU a=0xFFFFFFFF b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV a=0xFFFFFFF9(-7) b=2:
  - busy=1 for 10 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - With d_md_use=1 held, stall=1 from the start cycle through the last busy cycle and 0 in the following cycle.
- DIVU a=100 b=0 with hi=0x11, lo=0x22 preset via MTHI/MTLO:
  - busy for 10 cycles.
  - hi=0x11, lo=0x22 unchanged.
- MTHI a=0x12345678 -> hi=0x12345678 at the next edge; busy never asserts; stall=0 with d_md_use=1.
- Start DIVU 50/7; deassert reset_n asynchronously (mid-cycle) at busy cycle 4:
  - busy, hi, lo go to 0 immediately.
  - After release the block is in IDLE and accepts a new MULT.
